// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debounce scheduler.
// Event records carry the channel index and its new debounced level.
package debounce_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE,
        SCAN
    } sched_state_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            level;
    } deb_event_t;

endpackage

// File: rtl/deb_event_fifo.sv
// Synchronous show-ahead FIFO of debounce events.
// The head entry is driven straight from storage; a push into a full FIFO is dropped.
module deb_event_fifo
    import debounce_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  deb_event_t push_data,
    input  logic       pop,
    output deb_event_t head,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    deb_event_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer: shared tick prescaler, one-channel-per-clock scan,
// per-channel stability counters and an event FIFO for level changes.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_CH       = NUM_CH,
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         raw_in,
    output logic [N_CH-1:0]         debounced_out,
    output logic                    event_valid,
    output logic [$clog2(N_CH)-1:0] event_ch,
    output logic                    event_level,
    input  logic                    event_ready,
    output logic                    overflow,
    input  logic                    overflow_clr
);

    localparam int IW = $clog2(N_CH);
    localparam int PW = $clog2(TICK_DIV);

    logic [N_CH-1:0]  sync_q1;
    logic [N_CH-1:0]  sync_in;
    logic [PW-1:0]    presc;
    logic             tick;
    sched_state_t     state;
    sched_state_t     state_nx;
    logic [IW-1:0]    ch_idx;
    logic [IW-1:0]    ch_nx;
    logic [CNT_W-1:0] cnt [N_CH];
    logic             scanning;
    logic             differs;
    logic             qualified;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    deb_event_t       push_ev;
    deb_event_t       head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_in <= '0;
        end else begin
            sync_q1 <= raw_in;
            sync_in <= sync_q1;
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_nx;
            ch_idx <= ch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch_idx;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = SCAN;
                    ch_nx    = '0;
                end
            end
            SCAN: begin
                if (ch_idx == IW'(N_CH - 1)) begin
                    state_nx = IDLE;
                    ch_nx    = '0;
                end else begin
                    ch_nx = ch_idx + IW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                ch_nx    = '0;
            end
        endcase
    end

    assign scanning  = (state == SCAN);
    assign differs   = (sync_in[ch_idx] != debounced_out[ch_idx]);
    assign qualified = (cnt[ch_idx] == CNT_W'(STABLE_CNT - 1));
    assign push      = scanning && differs && qualified;
    assign push_ev   = '{ch: ch_idx, level: sync_in[ch_idx]};

    // Any sample that matches the debounced level restarts qualification.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_out <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (scanning) begin
            if (!differs) begin
                cnt[ch_idx] <= '0;
            end else if (qualified) begin
                debounced_out[ch_idx] <= sync_in[ch_idx];
                cnt[ch_idx]           <= '0;
            end else begin
                cnt[ch_idx] <= cnt[ch_idx] + CNT_W'(1);
            end
        end
    end

    assign event_valid = !empty;
    assign event_ch    = head.ch;
    assign event_level = head.level;
    assign pop         = event_valid && event_ready;

    deb_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(push_ev),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .drop     (drop)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    tick_outside_scan: assert property (
        @(posedge clk) disable iff (!reset_n) !(tick && scanning)
    );

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler (N_CH=4, TICK_DIV=10, STABLE_CNT=4).
// A timing/queue reference model runs alongside the directed and random stimulus.
module tb_debounce_scheduler;

    localparam int TD = 10;
    localparam int SC = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] raw_in;
    logic [3:0] debounced_out;
    logic       event_valid;
    logic [1:0] event_ch;
    logic       event_level;
    logic       event_ready;
    logic       overflow;
    logic       overflow_clr;

    debounce_scheduler #(
        .N_CH(4),
        .TICK_DIV(TD),
        .STABLE_CNT(SC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_in),
        .debounced_out(debounced_out),
        .event_valid  (event_valid),
        .event_ch     (event_ch),
        .event_level  (event_level),
        .event_ready  (event_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted since reset release; channel k is
    // examined at edge e when e-2-k is a tick cycle; sample is raw_in two edges back.
    int         ecount;
    logic [3:0] h1, h2, mdeb, samp;
    int         run [4];
    logic [2:0] mq [$];
    logic       movf;
    bit         mdrop;

    initial begin
        ecount = 0; h1 = 0; h2 = 0; mdeb = 0; movf = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                ecount = 0; h1 = 0; h2 = 0; mdeb = 0; movf = 0;
                for (int k = 0; k < 4; k++) run[k] = 0;
                mq.delete();
            end else begin
                ecount++;
                samp = h2; h2 = h1; h1 = raw_in;
                if (event_ready && mq.size() > 0) void'(mq.pop_front());
                mdrop = 0;
                for (int k = 0; k < 4; k++) begin
                    int d;
                    d = ecount - 2 - k;
                    if (d >= TD - 1 && (d - (TD - 1)) % TD == 0) begin
                        if (samp[k] == mdeb[k]) begin
                            run[k] = 0;
                        end else begin
                            run[k]++;
                            if (run[k] == SC) begin
                                run[k] = 0;
                                mdeb[k] = ~mdeb[k];
                                if (mq.size() < 4) mq.push_back({2'(k), mdeb[k]});
                                else mdrop = 1;
                            end
                        end
                    end
                end
                if (mdrop) movf = 1;
                else if (overflow_clr) movf = 0;
            end
        end
    end

    int pops = 0;
    logic [2:0] last_ev;
    bit any_valid;

    initial begin
        forever begin
            @(negedge clk);
            chk("sb_deb", debounced_out, mdeb);
            chk("sb_valid", event_valid, mq.size() > 0);
            if (mq.size() > 0) chk("sb_head", {event_ch, event_level}, mq[0]);
            chk("sb_ovf", overflow, movf);
            if (event_valid) any_valid = 1;
            if (event_valid && event_ready) begin
                pops++;
                last_ev = {event_ch, event_level};
            end
        end
    end

    task automatic align();
        do @(negedge clk); while (ecount % TD != 5);
    endtask

    task automatic pop_expect(input string name, input logic [2:0] ev);
        chk({name, "_valid"}, event_valid, 1'b1);
        chk({name, "_ev"}, {event_ch, event_level}, ev);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       ready;
        int         hold;
        logic [3:0] exp_deb;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{4'b0000, 1'b1, 60, 4'b0000, 1'b0};
        vecs[1] = '{4'b1010, 1'b1, 60, 4'b1010, 1'b0};
        vecs[2] = '{4'b0110, 1'b1, 60, 4'b0110, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, 60, 4'b0000, 1'b0};

        reset_n = 0; raw_in = 4'hF; event_ready = 0; overflow_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_deb", debounced_out, 4'h0);
        chk("rst_valid", event_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1;
        repeat (60) @(negedge clk);
        chk("t1_deb", debounced_out, 4'hF);
        chk("t1_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) pop_expect("t1_pop", {2'(i), 1'b1});
        chk("t1_empty", event_valid, 1'b0);

        for (int i = 0; i < 4; i++) begin
            align();
            raw_in = vecs[i].raw;
            event_ready = vecs[i].ready;
            repeat (vecs[i].hold) @(negedge clk);
            chk("vec_deb", debounced_out, vecs[i].exp_deb);
            chk("vec_ovf", overflow, vecs[i].exp_ovf);
        end

        begin
            int n0, waited;
            event_ready = 1;
            align();
            n0 = pops;
            raw_in = 4'b0100;
            waited = 0;
            while (!debounced_out[2] && waited < (SC + 1) * TD + 6) begin
                @(negedge clk);
                waited++;
            end
            chk("t2_rise", debounced_out[2], 1'b1);
            repeat (12) @(negedge clk);
            chk("t2_count", pops - n0, 1);
            chk("t2_ev", last_ev, 3'b101);
            chk("t2_deb", debounced_out, 4'b0100);
        end

        any_valid = 0;
        for (int r = 0; r < 2; r++) begin
            raw_in = 4'b0110;
            repeat (2 * TD) @(negedge clk);
            raw_in = 4'b0100;
            repeat (2 * TD) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        chk("t3_deb", debounced_out, 4'b0100);
        chk("t3_novalid", any_valid, 1'b0);

        event_ready = 0;
        align();
        raw_in = 4'b1011;
        repeat (60) @(negedge clk);
        align();
        raw_in = 4'b0100;
        repeat (60) @(negedge clk);
        chk("t4_deb", debounced_out, 4'b0100);
        chk("t4_ovf", overflow, 1'b1);
        chk("t4_head", {event_valid, event_ch, event_level}, 4'b1001);
        overflow_clr = 1;
        @(negedge clk);
        overflow_clr = 0;
        chk("t4_clr", overflow, 1'b0);

        // ch0 reaches its fourth differing sample 36 edges after alignment.
        align();
        raw_in = 4'b0101;
        repeat (35) @(negedge clk);
        event_ready = 1;
        @(negedge clk);
        event_ready = 0;
        chk("t5_deb", debounced_out, 4'b0101);
        chk("t5_ovf", overflow, 1'b0);
        pop_expect("t5_pop1", 3'b011);
        pop_expect("t5_pop2", 3'b100);
        pop_expect("t5_pop3", 3'b111);
        pop_expect("t5_pop4", 3'b001);
        chk("t5_empty", event_valid, 1'b0);

        // Reset lands in the ch2 scan cycle, one slot before ch3 would flip.
        align();
        raw_in = 4'b1101;
        repeat (37) @(negedge clk);
        chk("t6_pre_deb", debounced_out, 4'b0101);
        chk("t6_pre_valid", event_valid, 1'b0);
        #2 reset_n = 0;
        #1;
        chk("t6_deb", debounced_out, 4'b0000);
        chk("t6_valid", event_valid, 1'b0);
        chk("t6_ovf", overflow, 1'b0);
        raw_in = 4'b0000;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (60) @(negedge clk);
        chk("t6_post_deb", debounced_out, 4'b0000);
        chk("t6_post_valid", event_valid, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1)
                raw_in = raw_in ^ (4'b0001 << $urandom_range(0, 3));
            event_ready = 1'($urandom_range(0, 1));
            overflow_clr = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        overflow_clr = 0;
        event_ready = 1;
        repeat (80) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Multi-channel debounce controller: one shared sample-tick prescaler and one scan FSM serve N_CH raw button/switch inputs.
- Scans one channel per clock on each tick, maintains per-channel stability counters and drives the debounced levels.
- Queues edge events (channel, new level) into a small FIFO behind a valid/ready interface for the downstream control logic.

Parameters:
- N_CH, 4, number of raw input channels (2..16).
- TICK_DIV, 1000, clocks per sample tick; must be > N_CH+2.
- STABLE_CNT, 4, consecutive differing samples required to flip a channel (2..255).
- FIFO_DEPTH, 4, event FIFO entries (power of 2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- raw_in  input  N_CH  asynchronous raw inputs.
- debounced_out  output  N_CH  debounced levels.
- event_valid  output  1  FIFO head holds an event.
- event_ch  output  $clog2(N_CH)  channel of the head event.
- event_level  output  1  new debounced level of the head event.
- event_ready  input  1  consumer pops the head when asserted with event_valid.
- overflow  output  1  sticky: an event was dropped.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset is asynchronous, active-low. Every state element clears immediately, including mid-scan:
  - debounced_out=0, event_valid=0, overflow=0.
  - FIFO emptied, prescaler=0, all counters=0, FSM=IDLE.
- Synchronisation: raw_in passes through a 2-flop synchroniser per bit; sync_in is the second stage.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick pulses for one cycle when count==TICK_DIV-1.
- FSM states:
  - IDLE: on tick, go to SCAN with ch_idx=0.
  - SCAN: processes channel ch_idx in this cycle. If ch_idx==N_CH-1, go to IDLE; else ch_idx++.
- A tick never coincides with SCAN, because TICK_DIV > N_CH+2; an assertion checks this.
- Channel k is processed in cycle t+1+k after a tick in cycle t.
- Per-channel update while scanning channel k (cnt[k] is 8 bits):
  - If sync_in[k]==debounced_out[k]: cnt[k]<=0.
  - Else if cnt[k]==STABLE_CNT-1: debounced_out[k] flips, cnt[k]<=0, and event {k, sync_in[k]} is pushed.
  - Else: cnt[k]++.
  - Any matching sample resets the count, so a glitch restarts qualification.
- Latency: a clean raw edge reaches debounced_out after 2 sync clocks plus STABLE_CNT ticks, plus the scan-slot offset; worst case (STABLE_CNT+1)*TICK_DIV+N_CH+2 clocks.
- Event FIFO:
  - Show-ahead: event_valid, event_ch and event_level reflect the head combinationally from registers.
  - A pushed event is visible the cycle after the push edge.
  - Pop occurs when event_valid && event_ready. event_ready with an empty FIFO is a no-op.
  - Push while full without a pop: event dropped, overflow<=1; debounced_out still flips.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: push only; the event is visible next cycle.
  - Pointers are $clog2(FIFO_DEPTH) bits wide plus a wrap bit, and wrap naturally.
- overflow_clr:
  - Clears overflow on the next edge.
  - If a drop happens in the same cycle, set wins (overflow stays 1).
- Ordering: events leave the FIFO in push order, which is channel-ascending within a scan.

Decomposition:
- Shared package debounce_pkg:
  - typedef sched_state_t enum {IDLE, SCAN}.
  - typedef struct packed {ch, level} deb_event_t, with ch sized by a package localparam matched to N_CH.
  - localparam CNT_W=8.
- One sub-module: deb_event_fifo (synchronous show-ahead FIFO of deb_event_t, parameter DEPTH, ports push/pop/full/empty/drop).

Test Plan:
All scenarios use the bench config N_CH=4, TICK_DIV=10, STABLE_CNT=4, FIFO_DEPTH=4.
1. Reset: hold reset_n=0 for 3 clks with raw_in=4'hF. Then debounced_out=0, event_valid=0, overflow=0. After release and 4 ticks plus the scan offset, debounced_out=4'hF, and the FIFO holds 4 events in order ch0..ch3, all level 1.
2. Clean edge: raw_in[2] 0->1 and held, event_ready=1. Then debounced_out[2] rises within (4+1)*10+6 clks, exactly one event {ch=2, level=1}, and no change on other channels.
3. Glitch rejection: raw_in[1] pulses high for 2 ticks then low, twice. Then debounced_out[1] stays 0 and event_valid never asserts.
4. Overflow: event_ready=0, and channels 0..3 each toggle and settle twice (8 edges). Then the FIFO holds the first 4 events, overflow=1, and debounced_out tracks all inputs. Pulsing overflow_clr for one clock gives overflow=0 next clock.
5. Simultaneous push/pop: with the FIFO full, assert event_ready in the same cycle a new event is pushed. The count stays 4, no drop occurs, and overflow stays 0.
6. Reset mid-scan: assert reset_n=0 during the SCAN cycle for ch_idx=2, with a pending qualified flip on ch3. Everything clears asynchronously, no event is pushed, and debounced_out=0.
